// File: rtl/mem_stage_sram.sv
// MIPS MEM stage: performs each 32-bit load/store as two 16-bit accesses to an
// asynchronous SRAM (low half first). Holds the upstream pipeline with freeze
// while an access is in flight and owns the MEM/WB pipeline register.
module mem_stage_sram #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               WB_En_in,
    input  logic               MEM_R_En_in,
    input  logic               MEM_W_En_in,
    input  logic [4:0]         dest_in,
    input  logic [31:0]        ALU_result_in,
    input  logic [31:0]        readdata_in,
    output logic               freeze,
    output logic               WB_En,
    output logic               MEM_R_En,
    output logic [4:0]         dest,
    output logic [31:0]        ALU_result,
    output logic [31:0]        mem_data,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [31:0]   BASE     = 32'(ADDR_BASE);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [15:0]         low_q, low_d;
    logic [31:0]         load_q, load_d;

    logic                wb_en_q;
    logic                mem_r_en_q;
    logic [4:0]          dest_q;
    logic [31:0]         alu_q;
    logic [31:0]         mem_data_q;

    logic                mem_req;
    logic                is_store;
    logic                is_load;
    logic                phase_last;
    logic [SRAM_AW-2:0]  word_idx;

    assign mem_req    = MEM_R_En_in | MEM_W_En_in;
    // A combined read+write request is executed as a store only.
    assign is_store   = MEM_W_En_in;
    assign is_load    = MEM_R_En_in & ~MEM_W_En_in;
    assign phase_last = (cnt_q == CNT_LAST);
    // Word index relative to the SRAM base; wraps silently, byte offset dropped.
    assign word_idx   = (SRAM_AW-1)'((ALU_result_in - BASE) >> 2);

    // Sequencer next state, SRAM bus drive, load assembly and freeze.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        low_d       = low_q;
        load_d      = load_q;
        freeze      = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    freeze  = 1'b1;
                    state_d = LOW;
                    cnt_d   = '0;
                end
            end
            LOW: begin
                freeze    = 1'b1;
                sram_addr = {word_idx, 1'b0};
                if (is_store) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = readdata_in[15:0];
                end
                if (phase_last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (is_load) low_d = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HIGH: begin
                freeze    = 1'b1;
                sram_addr = {word_idx, 1'b1};
                if (is_store) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = readdata_in[31:16];
                end
                if (phase_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (is_load) load_d = {sram_dq_in, low_q};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, halfword latches and the MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            low_q      <= '0;
            load_q     <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            dest_q     <= '0;
            alu_q      <= '0;
            mem_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            low_q   <= low_d;
            load_q  <= load_d;
            if (freeze) begin
                // Bubble into WB while the access is in flight.
                wb_en_q    <= 1'b0;
                mem_r_en_q <= 1'b0;
            end else begin
                wb_en_q    <= WB_En_in;
                mem_r_en_q <= MEM_R_En_in;
                dest_q     <= dest_in;
                alu_q      <= ALU_result_in;
                if (state_q == DONE) mem_data_q <= load_q;
            end
        end
    end

    assign WB_En      = wb_en_q;
    assign MEM_R_En   = mem_r_en_q;
    assign dest       = dest_q;
    assign ALU_result = alu_q;
    assign mem_data   = mem_data_q;

endmodule
